sha1_ctrl: RTL
==============

# sha1_ctrl

Block-level sequencer for the `sha1block` compression core. It accepts pre-padded 512-bit message blocks as a stream of 32-bit words into a two-entry ping-pong buffer, and serves words to the core by `raddr`. It restarts the core once per block, folds each block's `a..e` into the running hash state `H0..H4`, and emits the 160-bit digest when a message's last block completes. It sits between the message source (padding is the source's job) and the `sha1block` instance.

## Interface
Parameters: none. The initialisation vector is fixed: 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.

Ports:
- `clk`  in  1  system clock, rising edge. One clock for the whole block.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  source offers `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  32  message word, big-endian, word 0 of each block first.
- `in_first`  in  1  sampled with word 0 only; block starts a new message.
- `in_last`  in  1  sampled with word 15 only; block ends the message.
- `core_restart`  out  1  one-cycle start pulse to `sha1block.restart`.
- `core_h0`..`core_h4`  out  32 each  current hash state H0..H4 to the core.
- `core_word`  out  32  active buffer word at `core_raddr`, combinational.
- `core_raddr`  in  4  word index requested by the core.
- `core_a`..`core_e`  in  32 each  core working variables.
- `core_ready`  in  1  core finished the 80 rounds; `a..e` are final.
- `digest`  out  160  {H0,H1,H2,H3,H4} of the completed message.
- `digest_valid`  out  1  one-cycle pulse; `digest` is new.

## Operation
- Buffers: two 16x32 entries, each with a `full` flag plus captured `first`/`last` flags.
- Fill pointer and word counter (0..15) advance on each `in_valid && in_ready`.
- On word 15: set the entry's `full`, toggle the fill pointer, clear the counter.
- `in_ready` = fill entry not `full`. `in_first`/`in_last` are ignored on every word other than 0 and 15 respectively.
- Compute pointer selects the entry feeding `core_word`.
- FSM:
  - IDLE: if the compute entry is `full`, go to START. If its `first` is set, load H with the IV on this transition.
  - START: `core_restart`=1 for exactly one cycle, then go to RUN.
  - RUN: wait for `core_ready`. Ignore `core_ready` in the first RUN cycle, because the core is still clearing the previous block's ready. On `core_ready`, go to UPDATE.
  - UPDATE:
    - Hi <= Hi + core_x, each sum mod 2^32.
    - Clear the compute entry's `full` and toggle the compute pointer.
    - If the entry's `last` is set, register `digest` from the new H and pulse `digest_valid` next cycle.
    - If the other entry is already `full`, go directly to START, reloading IV if its `first` is set. Otherwise go to IDLE.
- H is stable from START through UPDATE; it changes only on IV load or the UPDATE add.
- A block with `first`=0 following a completed message chains from the stale H. This is legal and is not flagged.
- A block may be both `first` and `last`.
- `digest` holds its value until the next `digest_valid`.

## Timing
- Reset values: `in_ready`=0 during `rst`, 1 the first cycle after. `core_restart`=0, `digest`=0, `digest_valid`=0, H=IV, both buffers empty, pointers 0, FSM=IDLE.
- Latency: word 15 is accepted in cycle k. IDLE sees `full` in k+1, START runs in k+2, RUN starts in k+3.
- If the first valid `core_ready` is in cycle r: UPDATE in r+1, `digest_valid` in r+2.
- Next-block restart: r+2 when the other entry is full (UPDATE→START). Otherwise one cycle after that entry fills.
- Simultaneous events:
  - Filling one entry while the other computes is allowed.
  - Accepting a word into an entry in the same cycle UPDATE frees it cannot happen (`in_ready` was 0 for that entry).
  - Freeing an entry in UPDATE raises `in_ready` the next cycle.
- `rst` mid-operation: partial and full buffers are discarded, the FSM returns to IDLE, and H returns to IV. No `digest_valid` is produced for the abandoned message. Any stale `core_ready` is ignored until the next START.

## Test plan
- "abc": one block 61626380, 0 x14, 00000018, `first`=`last`=1 -> one `digest_valid`, `digest`=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Empty message: 80000000, 0 x15 -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", streamed with no gaps -> 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - The second block must start via UPDATE→START.
  - Exactly one `digest_valid`.
- Back-to-back "abc" then empty message, with random `in_valid` gaps -> two digests in order with the values above.
  - `in_ready` drops only while both entries are full.
- Reset mid-RUN of the two-block message's first block, then send "abc" -> no digest for the aborted message; next `digest`=a9993e36…9cd0d89d.
- `in_first`/`in_last` toggled on words 1..14 of an "abc" block -> no effect; digest unchanged.

Source files
------------

// File: rtl/sha1_ctrl.sv
// Block sequencer for the sha1block core: ping-pong message buffer, per-block
// restart, H0..H4 accumulation and digest emission on the message's last block.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | wait for the compute entry to become full
// S_START     | pulse core_restart for one cycle
// S_RUN_FIRST | first cycle after restart; core_ready is stale, ignore it
// S_RUN       | wait for core_ready
// S_UPDATE    | fold a..e into H, free the entry, maybe emit digest
module sha1_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_first,
   input  logic         in_last,
   output logic         core_restart,
   output logic [31:0]  core_h0,
   output logic [31:0]  core_h1,
   output logic [31:0]  core_h2,
   output logic [31:0]  core_h3,
   output logic [31:0]  core_h4,
   output logic [31:0]  core_word,
   input  logic [3:0]   core_raddr,
   input  logic [31:0]  core_a,
   input  logic [31:0]  core_b,
   input  logic [31:0]  core_c,
   input  logic [31:0]  core_d,
   input  logic [31:0]  core_e,
   input  logic         core_ready,
   output logic [159:0] digest,
   output logic         digest_valid
);

   localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                  32'h10325476, 32'hC3D2E1F0};

   typedef enum logic [2:0] {S_IDLE, S_START, S_RUN_FIRST, S_RUN, S_UPDATE} state_t;

   state_t         state_q, state_d;
   logic [31:0]    mem_q [2][16];
   logic [1:0]     full_q, first_q, last_q;
   logic           fill_ptr_q, comp_ptr_q;
   logic [3:0]     wcnt_q;
   logic [159:0]   h_q, h_d, h_sum;
   logic [159:0]   digest_q, digest_d;
   logic           dv_q, dv_d;
   logic           accept, load_iv, do_update;

   assign in_ready     = ~rst & ~full_q[fill_ptr_q];
   assign accept       = in_valid & in_ready;
   assign core_word    = mem_q[comp_ptr_q][core_raddr];
   assign core_h0      = h_q[159:128];
   assign core_h1      = h_q[127:96];
   assign core_h2      = h_q[95:64];
   assign core_h3      = h_q[63:32];
   assign core_h4      = h_q[31:0];
   assign digest       = digest_q;
   assign digest_valid = dv_q;

   assign h_sum = {h_q[159:128] + core_a, h_q[127:96] + core_b, h_q[95:64] + core_c,
                   h_q[63:32] + core_d, h_q[31:0] + core_e};

   always_comb begin
      state_d      = state_q;
      core_restart = 1'b0;
      load_iv      = 1'b0;
      do_update    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (full_q[comp_ptr_q]) begin
               state_d = S_START;
               load_iv = first_q[comp_ptr_q];
            end
         end
         S_START: begin
            core_restart = 1'b1;
            state_d      = S_RUN_FIRST;
         end
         S_RUN_FIRST: state_d = S_RUN;
         S_RUN: begin
            if (core_ready) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            do_update = 1'b1;
            if (full_q[~comp_ptr_q]) begin
               state_d = S_START;
               load_iv = first_q[~comp_ptr_q];
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // IV reload wins over the add so a chained first block starts clean, while
   // the digest still captures the finished sum.
   always_comb begin
      h_d      = h_q;
      dv_d     = 1'b0;
      digest_d = digest_q;
      if (do_update) begin
         h_d = h_sum;
         if (last_q[comp_ptr_q]) begin
            dv_d     = 1'b1;
            digest_d = h_sum;
         end
      end
      if (load_iv) h_d = IV;
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[fill_ptr_q][wcnt_q] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         full_q     <= 2'b00;
         first_q    <= 2'b00;
         last_q     <= 2'b00;
         fill_ptr_q <= 1'b0;
         comp_ptr_q <= 1'b0;
         wcnt_q     <= 4'd0;
         h_q        <= IV;
         digest_q   <= '0;
         dv_q       <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         digest_q <= digest_d;
         dv_q     <= dv_d;
         if (accept) begin
            wcnt_q <= wcnt_q + 4'd1;
            if (wcnt_q == 4'd0) first_q[fill_ptr_q] <= in_first;
            if (wcnt_q == 4'd15) begin
               last_q[fill_ptr_q] <= in_last;
               full_q[fill_ptr_q] <= 1'b1;
               fill_ptr_q         <= ~fill_ptr_q;
            end
         end
         if (do_update) begin
            full_q[comp_ptr_q] <= 1'b0;
            comp_ptr_q         <= ~comp_ptr_q;
         end
      end
   end

endmodule
